// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers (start/busy/done handshake).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply, IDLE->FIX for MULT/MULTU.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is only sampled while idle (busy=0); busy rises the cycle after an
  // accepted start, done pulses during the single FIX cycle, and busy drops on the edge after it.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_is_div;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic [WIDTH-1:0]       r_a_mag;
  logic [WIDTH-1:0]       r_b_mag;
  logic [WIDTH-1:0]       r_a_raw;
  logic [2*WIDTH-1:0]     r_acc;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_div_zero;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  logic                   w_signed;
  logic                   w_div_zero_req;
  logic                   w_direct;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic [2*WIDTH-1:0]     w_acc_init;
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_rem_sh;
  logic [WIDTH:0]         w_diff;
  logic [2*WIDTH-1:0]     w_div_next;
  logic [2*WIDTH-1:0]     w_prod_fix;
  logic [WIDTH-1:0]       w_fix_hi;
  logic [WIDTH-1:0]       w_fix_lo;

  assign w_signed       = ~op[0];
  assign w_div_zero_req = op[1] && (B == '0);
  assign w_a_mag        = (w_signed && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
  assign w_b_mag        = (w_signed && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]     w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_direct    = w_div_zero_req || !op[1];
  assign w_acc_init  = op[1] ? {{WIDTH{1'b0}}, w_a_mag} : w_fast_prod;
`else
  assign w_direct    = w_div_zero_req;
  // Multiply keeps the multiplier in the low half and shifts it out; divide keeps the dividend there.
  assign w_acc_init  = op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
`endif

  // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a_mag};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring step: the shifted remainder needs WIDTH+1 bits since it may exceed 2^WIDTH-1.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_b_mag};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = r_neg_q ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        w_fix_hi = r_neg_r ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_a_raw    <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div   <= op[1];
            r_a_mag    <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_a_raw    <= A;
            r_neg_q    <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r    <= w_signed & A[WIDTH-1];
            r_div_zero <= w_div_zero_req;
            r_acc      <= w_acc_init;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            if (w_direct) begin
              r_state <= S_FIX;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FIX;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_zero    = r_div_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  // Latency = index of the cycle in which done is high, counting the cycle after the start edge as 1.
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int ZERO_LAT = 1;

  logic        clk = 1'b0;
  logic        reset, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] A, B, wr_data;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  // ---- clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- driver: issues one op and observes it to the idle cycle after done (no checking here)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdz, output logic busy_seen, output logic clean);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo; clean = 1'b1;
    op = o; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    busy_seen = busy;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (hi !== hi0 || lo !== lo0 || busy !== 1'b1) clean = 1'b0;
      step();
      lat++;
    end
    if (hi !== hi0 || lo !== lo0 || busy !== 1'b1) clean = 1'b0;
    step();
    if (done !== 1'b0 || busy !== 1'b0) clean = 1'b0;
    rhi = hi; rlo = lo; rdz = div_zero;
  endtask

  // ---- scenarios
  task automatic test_reset();
    int lat; logic [31:0] rhi, rlo; logic rdz, bs, cl;
    reset = 1'b0; step(); step();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b dz=%b required 0 0 0", busy, done, div_zero); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", hi, lo); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++;
      $display("FAIL reset_state: %0d required 0", dbg_state); end
    reset = 1'b1; step();
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h11; step();
    wr_lo = 1'b0; wr_data = 32'h22; step(); wr_hi = 1'b0;
    n_tests++; if (hi !== 32'h22 || lo !== 32'h11) begin n_fail++;
      $display("FAIL write_both: hi=%h lo=%h required 22 11", hi, lo); end
    op = OP_DIV; A = 32'd100; B = 32'd7; start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    n_tests++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL midop_busy: busy=%b required 1", busy); end
    reset = 1'b0; step(); step();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin n_fail++;
      $display("FAIL midop_reset: busy=%b done=%b state=%0d required 0 0 0", busy, done, dbg_state); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
      $display("FAIL midop_reset_hilo: hi=%h lo=%h required 0 0", hi, lo); end
    reset = 1'b1; step();
    run_op(OP_MULTU, 32'd3, 32'd5, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h0 || rlo !== 32'd15) begin n_fail++;
      $display("FAIL multu_3x5: hi=%h lo=%h required 0 f", rhi, rlo); end
    n_tests++; if (lat !== MUL_LAT) begin n_fail++;
      $display("FAIL multu_lat: %0d required %0d", lat, MUL_LAT); end
  endtask

  task automatic test_mult();
    int lat; logic [31:0] rhi, rlo; logic rdz, bs, cl;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'hFFFF_FFFF || rlo !== 32'hFFFF_FFFA) begin n_fail++;
      $display("FAIL mult_neg2x3: hi=%h lo=%h required ffffffff fffffffa", rhi, rlo); end
    n_tests++; if (lat !== MUL_LAT || cl !== 1'b1) begin n_fail++;
      $display("FAIL mult_timing: lat=%0d clean=%b required %0d 1", lat, cl, MUL_LAT); end
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h2 || rlo !== 32'hFFFF_FFFA) begin n_fail++;
      $display("FAIL multu_big: hi=%h lo=%h required 2 fffffffa", rhi, rlo); end
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h0 || rlo !== 32'd21) begin n_fail++;
      $display("FAIL mult_negxneg: hi=%h lo=%h required 0 15", rhi, rlo); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] rhi, rlo; logic rdz, bs, cl;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'hFFFF_FFFF || rlo !== 32'hFFFF_FFFD) begin n_fail++;
      $display("FAIL div_neg7_2: hi=%h lo=%h required ffffffff fffffffd", rhi, rlo); end
    n_tests++; if (lat !== DIV_LAT || cl !== 1'b1 || rdz !== 1'b0) begin n_fail++;
      $display("FAIL div_timing: lat=%0d clean=%b dz=%b required %0d 1 0", lat, cl, rdz, DIV_LAT); end
    run_op(OP_DIVU, 32'd7, 32'd2, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'd1 || rlo !== 32'd3) begin n_fail++;
      $display("FAIL divu_7_2: hi=%h lo=%h required 1 3", rhi, rlo); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h0 || rlo !== 32'h8000_0000 || rdz !== 1'b0) begin n_fail++;
      $display("FAIL div_min_m1: hi=%h lo=%h dz=%b required 0 80000000 0", rhi, rlo, rdz); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h0000_FFFF || rlo !== 32'h0000_FFFF) begin n_fail++;
      $display("FAIL divu_big: hi=%h lo=%h required ffff ffff", rhi, rlo); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rhi, rlo; logic rdz, bs, cl;
    run_op(OP_DIVU, 32'h1234, 32'h0, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h1234 || rlo !== 32'hFFFF_FFFF || rdz !== 1'b1) begin n_fail++;
      $display("FAIL divzero_result: hi=%h lo=%h dz=%b required 1234 ffffffff 1", rhi, rlo, rdz); end
    n_tests++; if (lat !== ZERO_LAT || cl !== 1'b1) begin n_fail++;
      $display("FAIL divzero_lat: lat=%0d clean=%b required %0d 1", lat, cl, ZERO_LAT); end
    op = OP_DIVU; A = 32'd9; B = 32'd4; start = 1'b1; step(); start = 1'b0;
    n_tests++; if (div_zero !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL divzero_clear: dz=%b busy=%b required 0 1", div_zero, busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin step(); lat++; end
    step();
    n_tests++; if (hi !== 32'd1 || lo !== 32'd2) begin n_fail++;
      $display("FAIL divu_9_4: hi=%h lo=%h required 1 2", hi, lo); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [31:0] rhi, rlo, lo0; logic rdz, bs, cl;
    lo0 = lo;
    op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    op = OP_MULT; A = 32'd5; B = 32'd5; start = 1'b1; wr_lo = 1'b1; wr_data = 32'hAA;
    step();
    start = 1'b0; wr_lo = 1'b0;
    n_tests++; if (lo !== lo0) begin n_fail++;
      $display("FAIL busy_write: lo=%h required %h", lo, lo0); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin step(); lat++; end
    step();
    n_tests++; if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b0) begin n_fail++;
      $display("FAIL busy_start: hi=%h lo=%h busy=%b required 2 e 0", hi, lo, busy); end
    wr_hi = 1'b1; wr_data = 32'h55; step(); wr_hi = 1'b0;
    n_tests++; if (hi !== 32'h55 || lo !== 32'd14) begin n_fail++;
      $display("FAIL idle_wr_hi: hi=%h lo=%h required 55 e", hi, lo); end
    wr_lo = 1'b1; wr_data = 32'h77;
    run_op(OP_DIVU, 32'd9, 32'd3, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rhi !== 32'h0 || rlo !== 32'd3) begin n_fail++;
      $display("FAIL start_beats_wr: hi=%h lo=%h required 0 3", rhi, rlo); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rhi, rlo; logic rdz, bs, cl;
    run_op(OP_MULTU, 32'd7, 32'd6, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (rlo !== 32'd42 || rhi !== 32'h0 || cl !== 1'b1) begin n_fail++;
      $display("FAIL b2b_first: hi=%h lo=%h clean=%b required 0 2a 1", rhi, rlo, cl); end
    run_op(OP_DIVU, 32'd42, 32'd5, lat, rhi, rlo, rdz, bs, cl);
    n_tests++; if (bs !== 1'b1 || cl !== 1'b1 || lat !== DIV_LAT) begin n_fail++;
      $display("FAIL b2b_accept: busy=%b clean=%b lat=%0d required 1 1 %0d", bs, cl, lat, DIV_LAT); end
    n_tests++; if (rhi !== 32'd2 || rlo !== 32'd8) begin n_fail++;
      $display("FAIL b2b_second: hi=%h lo=%h required 2 8", rhi, rlo); end
  endtask

  // ---- sequence and report
  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
